// File: rtl/iir_par_gen.sv
`default_nettype none
// ============================================================================
//  Module   : iir_par_gen
//  Purpose  : Two-path (even/odd polyphase) first-order look-ahead IIR filter
//             with shift-add coefficients, guard bits and optional output
//             saturation. Single clock domain, sample-valid strobe.
//
//             y[n] = x[n] + A(x[n-1]) + B(y[n-2])
//             A(v) = (v>>>A1) + (v>>>A2),  B(v) = (v>>>B1) + (v>>>B2)
//
//  Ports    : clk      - system clock, all logic on posedge
//             reset    - synchronous active-high reset
//             x_in     - signed input sample (W+1 bits)
//             x_valid  - x_in accepted on this posedge when high
//             bypass   - 1: y_out carries the delayed input sample
//             y_out    - signed output sample (W+1 bits), held between strobes
//             y_valid  - one-cycle strobe, y_out valid
//             ovf      - sticky saturation flag
//  Revision : 1.0  initial release
// ============================================================================
module iir_par_gen #(
    parameter int W   = 14,
    parameter int G   = 3,
    parameter int A1  = 1,
    parameter int A2  = 2,
    parameter int B1  = 1,
    parameter int B2  = 4,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W:0]   x_in,
    input  logic         x_valid,
    input  logic         bypass,
    output logic [W:0]   y_out,
    output logic         y_valid,
    output logic         ovf
);

    localparam int c_WI = W + 1 + G;

    // Output clamp limits expressed in the internal width.
    localparam logic signed [c_WI-1:0] c_YMAX = {{(G+1){1'b0}}, {W{1'b1}}};
    localparam logic signed [c_WI-1:0] c_YMIN = {{(G+1){1'b1}}, {W{1'b0}}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic signed [c_WI-1:0] r_xd;       // x[n-1], last accepted input
    logic signed [c_WI-1:0] r_yh_e;     // history of the even path
    logic signed [c_WI-1:0] r_yh_o;     // history of the odd path
    logic                   r_phase;    // 0 = even, toggles per accepted sample

    logic signed [c_WI-1:0] r_s1;       // stage 1: x[n] + A(x[n-1])
    logic                   r_s1_ph;
    logic                   r_s1_byp;
    logic        [W:0]      r_s1_x;     // raw input for the bypass path
    logic                   r_s1_vld;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic signed [c_WI-1:0] w_x_ext;
    logic signed [c_WI-1:0] w_a;
    logic signed [c_WI-1:0] w_yh;
    logic signed [c_WI-1:0] w_b;
    logic signed [c_WI-1:0] w_y;
    logic        [W:0]      w_yo;
    logic                   w_clamp;

    assign w_x_ext = {{G{x_in[W]}}, x_in};
    assign w_a     = (r_xd >>> A1) + (r_xd >>> A2);

    // The register of the sample's own phase was last written two accepted
    // samples ago, so it holds y[n-2] even for back-to-back input.
    assign w_yh    = r_s1_ph ? r_yh_o : r_yh_e;
    assign w_b     = (w_yh >>> B1) + (w_yh >>> B2);
    assign w_y     = r_s1 + w_b;

    generate
        if (SAT != 0) begin : g_sat
            always_comb begin
                w_yo    = w_y[W:0];
                w_clamp = 1'b0;
                if (w_y > c_YMAX) begin
                    w_yo    = c_YMAX[W:0];
                    w_clamp = 1'b1;
                end else if (w_y < c_YMIN) begin
                    w_yo    = c_YMIN[W:0];
                    w_clamp = 1'b1;
                end
            end
        end else begin : g_wrap
            assign w_yo    = w_y[W:0];
            assign w_clamp = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 1: feed-forward term, input history and phase
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xd     <= '0;
            r_phase  <= 1'b0;
            r_s1     <= '0;
            r_s1_ph  <= 1'b0;
            r_s1_byp <= 1'b0;
            r_s1_x   <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= x_valid;
            if (x_valid) begin
                r_s1     <= w_x_ext + w_a;
                r_s1_ph  <= r_phase;
                r_s1_byp <= bypass;
                r_s1_x   <= x_in;
                r_xd     <= w_x_ext;
                r_phase  <= ~r_phase;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: feedback term, history update and output
    // The history updates even in bypass so leaving bypass is transient-free.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_yh_e  <= '0;
            r_yh_o  <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            y_valid <= r_s1_vld;
            if (r_s1_vld) begin
                if (r_s1_ph) begin
                    r_yh_o <= w_y;
                end else begin
                    r_yh_e <= w_y;
                end
                y_out <= r_s1_byp ? r_s1_x : w_yo;
                if (w_clamp && !r_s1_byp) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_par_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_par_gen
//  Purpose  : Self-checking bench for iir_par_gen. A saturating and a
//             wrapping instance share the stimulus; both are compared every
//             cycle against an arithmetic model of the recursion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iir_par_gen;

    localparam int W  = 14;
    localparam int G  = 3;
    localparam int A1 = 1;
    localparam int A2 = 2;
    localparam int B1 = 1;
    localparam int B2 = 4;
    localparam longint c_WI   = W + 1 + G;
    localparam longint c_YMAX = (64'sd1 <<< W) - 1;
    localparam longint c_YMIN = -(64'sd1 <<< W);

    logic         clk = 1'b0;
    logic         reset;
    logic [W:0]   x_in;
    logic         x_valid;
    logic         bypass;
    logic [W:0]   y_out,   y_out_w;
    logic         y_valid, y_valid_w;
    logic         ovf,     ovf_w;

    always #5 clk = ~clk;

    iir_par_gen #(.W(W), .G(G), .A1(A1), .A2(A2), .B1(B1), .B2(B2), .SAT(1)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .bypass(bypass),
        .y_out(y_out), .y_valid(y_valid), .ovf(ovf)
    );

    iir_par_gen #(.W(W), .G(G), .A1(A1), .A2(A2), .B1(B1), .B2(B2), .SAT(0)) dut_w (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .bypass(bypass),
        .y_out(y_out_w), .y_valid(y_valid_w), .ovf(ovf_w)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state (history over accepted samples)
    longint xm1, ym1, ym2;
    bit     ovf_m;
    longint held_y, held_yw;
    // Result of the sample accepted on the previous edge, due after the next one
    bit     pend_v;
    longint pend_y, pend_yw;
    bit     pend_clamp;
    // Outputs seen on y_valid strobes, for the fixed-value tables
    longint got[$];

    function automatic longint fdiv(input longint v, input longint d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic longint wrap_to(input longint v, input longint bits);
        longint m, r;
        m = 64'sd1 <<< bits;
        r = v % m;
        if (r < 0) r = r + m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic longint fa(input longint v);
        return fdiv(v, 64'sd1 <<< A1) + fdiv(v, 64'sd1 <<< A2);
    endfunction

    function automatic longint fb(input longint v);
        return fdiv(v, 64'sd1 <<< B1) + fdiv(v, 64'sd1 <<< B2);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        xm1 = 0; ym1 = 0; ym2 = 0;
        ovf_m = 1'b0;
        held_y = 0; held_yw = 0;
        pend_v = 1'b0; pend_y = 0; pend_yw = 0; pend_clamp = 1'b0;
    endtask

    // One clock cycle with the given inputs; checks outputs 1 time unit after the edge.
    task automatic step(input bit v, input int x, input bit b);
        bit     nv, nclamp;
        longint ny, nyw, xs, y;
        reset   = 1'b0;
        x_valid = v;
        x_in    = x[W:0];
        bypass  = b;
        nv = 1'b0; ny = 0; nyw = 0; nclamp = 1'b0;
        if (v) begin
            xs  = longint'(x);
            y   = wrap_to(xs + fa(xm1) + fb(ym2), c_WI);
            ym2 = ym1; ym1 = y; xm1 = xs;
            nv  = 1'b1;
            if (b) begin
                ny = xs; nyw = xs;
            end else begin
                ny = y;
                if (y > c_YMAX) begin ny = c_YMAX; nclamp = 1'b1; end
                if (y < c_YMIN) begin ny = c_YMIN; nclamp = 1'b1; end
                nyw = wrap_to(y, W + 1);
            end
        end
        @(posedge clk); #1;
        if (pend_v) begin
            held_y  = pend_y;
            held_yw = pend_yw;
            if (pend_clamp) ovf_m = 1'b1;
        end
        chk("y_valid",   y_valid,           pend_v);
        chk("y_out",     $signed(y_out),    held_y);
        chk("ovf",       ovf,               ovf_m);
        chk("y_valid_w", y_valid_w,         pend_v);
        chk("y_out_w",   $signed(y_out_w),  held_yw);
        chk("ovf_w",     ovf_w,             1'b0);
        if (y_valid) got.push_back(longint'($signed(y_out)));
        pend_v = nv; pend_y = ny; pend_yw = nyw; pend_clamp = nclamp;
    endtask

    // One reset cycle, with x_valid asserted to confirm it is ignored.
    task automatic do_reset();
        reset   = 1'b1;
        x_valid = 1'b1;
        x_in    = 15'sd1234;
        bypass  = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("rst_y_valid", y_valid, 1'b0);
        chk("rst_y_out",   $signed(y_out), 0);
        chk("rst_ovf",     ovf, 1'b0);
        chk("rst_y_out_w", $signed(y_out_w), 0);
    endtask

    task automatic chk_table(input string tag, input longint t0, input longint t1,
                             input longint t2, input longint t3);
        longint tbl[4];
        tbl[0] = t0; tbl[1] = t1; tbl[2] = t2; tbl[3] = t3;
        chk({tag, "_count"}, got.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk(tag, got[i], tbl[i]);
        end
    endtask

    initial begin
        reset = 1'b1; x_valid = 1'b0; x_in = '0; bypass = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Positive impulse, back-to-back
        got.delete();
        step(1, 1000, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        chk_table("imp_pos", 1000, 750, 562, 421);
        if (got.size() > 4) chk("imp_pos4", got[4], 316);

        // Negative impulse: floor behaviour of the shifts
        do_reset();
        got.delete();
        step(1, -1000, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk_table("imp_neg", -1000, -750, -563, -422);

        // Gapped impulse: x_valid every third cycle
        do_reset();
        got.delete();
        step(1, 1000, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        end
        chk_table("imp_gap", 1000, 750, 562, 421);

        // Positive saturation, then negative
        do_reset();
        for (int i = 0; i < 40; i++) step(1, 16383, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("sat_pos_ovf", ovf, 1'b1);
        do_reset();
        for (int i = 0; i < 40; i++) step(1, -16384, 0);
        chk("sat_neg_out", $signed(y_out), -16384);

        // Bypass ramp, then drop bypass mid-stream
        do_reset();
        for (int i = 1; i <= 20; i++) step(1, i, 1);
        for (int i = 0; i < 20; i++) step(1, int'($urandom_range(0, 4000)) - 2000, 0);

        // Reset mid-stream during an impulse response, then a fresh impulse
        step(1, 1000, 0);
        step(1, 0, 0); step(1, 0, 0);
        do_reset();
        got.delete();
        step(1, 1000, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk_table("imp_after_rst", 1000, 750, 562, 421);

        // Randomized traffic: gaps, bypass toggles, occasional large inputs and resets
        for (int i = 0; i < 600; i++) begin
            int  xr;
            bit  vr, br;
            vr = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) xr = int'($urandom_range(0, 32767)) - 16384;
            else                           xr = int'($urandom_range(0, 8000)) - 4000;
            if ($urandom_range(0, 150) == 0) do_reset();
            else                             step(vr, xr, br);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
